// File: rtl/timer_apb_slave.sv
// ============================================================================
// Module   : timer_apb_slave
// Brief    : APB completer and TDR/TCR/TSR register file for the 8-bit timer.
//            Optional TIER register and tmr_int output when TIMER_INT_EN is
//            defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module timer_apb_slave #(
  parameter int         ADDR_W      = 8,
  parameter int         WAIT_CYCLES = 0,
  parameter logic [7:0] TDR_RST     = 8'h00
) (
  input  logic              pclk,
  input  logic              presetn,
  input  logic              psel,
  input  logic              penable,
  input  logic              pwrite,
  input  logic [ADDR_W-1:0] paddr,
  input  logic [7:0]        pwdata,
  output logic [7:0]        prdata,
  output logic              pready,
  output logic              pslverr,
  output logic [7:0]        tdr,
  output logic              load,
  output logic              cnt_dw,
  output logic              cnt_en,
  output logic [1:0]        clk_sel,
  input  logic [7:0]        tcnt,
  input  logic              ovf_set,
`ifdef TIMER_INT_EN
  output logic              tmr_int,
`endif
  input  logic              udf_set
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_WAIT   = 2'd3
  } state_t;

  localparam logic [3:0] c_wait_init = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  state_t     r_state;
  state_t     w_phase;
  logic [3:0] r_wait_cnt;
  logic [1:0] r_tsr;
  logic [2:0] w_reg;
  logic       w_hi_zero;
  logic       w_valid;
  logic       w_err;
  logic       w_commit;
  logic [7:0] w_rdata;
  logic [1:0] w_tsr_keep;
`ifdef TIMER_INT_EN
  logic [1:0] r_tier;
`endif

  assign w_reg     = paddr[2:0];
  assign w_hi_zero = ((paddr >> 3) == '0);

  always_comb begin
    w_valid = 1'b0;
    case (w_reg)
      3'd0, 3'd1, 3'd2, 3'd3: w_valid = w_hi_zero;
`ifdef TIMER_INT_EN
      3'd4:                   w_valid = w_hi_zero;
`endif
      default:                w_valid = 1'b0;
    endcase
  end

  // TCNT is read-only, so a write to it is an error response
  assign w_err = !w_valid || (pwrite && (w_reg == 3'd3));

  always_comb begin
    w_rdata = 8'h00;
    case (w_reg)
      3'd0:    w_rdata = tdr;
      3'd1:    w_rdata = {2'b00, cnt_dw, cnt_en, 2'b00, clk_sel};
      3'd2:    w_rdata = {6'b000000, r_tsr};
      3'd3:    w_rdata = tcnt;
`ifdef TIMER_INT_EN
      3'd4:    w_rdata = {6'b000000, r_tier};
`endif
      default: w_rdata = 8'h00;
    endcase
    if (!w_valid) begin
      w_rdata = 8'h00;
    end
  end

  // A setup phase is recognised in the same cycle it appears on the bus,
  // so the registered completion can land on the first ACCESS cycle.
  always_comb begin
    w_phase = r_state;
    if ((r_state == ST_IDLE) && psel && !penable) begin
      w_phase = ST_SETUP;
    end
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      r_state    <= ST_IDLE;
      r_wait_cnt <= 4'd0;
      pready     <= 1'b0;
      pslverr    <= 1'b0;
      prdata     <= 8'h00;
    end else begin
      pready  <= 1'b0;
      pslverr <= 1'b0;
      prdata  <= 8'h00;
      case (w_phase)
        ST_SETUP: begin
          if (WAIT_CYCLES == 0) begin
            r_state <= ST_ACCESS;
            pready  <= 1'b1;
            pslverr <= w_err;
            prdata  <= pwrite ? 8'h00 : w_rdata;
          end else begin
            r_state    <= ST_WAIT;
            r_wait_cnt <= c_wait_init;
          end
        end
        ST_WAIT: begin
          if (!psel) begin
            r_state <= ST_IDLE;
          end else if (r_wait_cnt == 4'd0) begin
            r_state <= ST_ACCESS;
            pready  <= 1'b1;
            pslverr <= w_err;
            prdata  <= pwrite ? 8'h00 : w_rdata;
          end else begin
            r_wait_cnt <= r_wait_cnt - 4'd1;
          end
        end
        ST_ACCESS: r_state <= ST_IDLE;
        default:   r_state <= ST_IDLE;
      endcase
    end
  end

  assign w_commit   = (r_state == ST_ACCESS) && psel && penable && pwrite && !w_err;
  assign w_tsr_keep = (w_commit && (w_reg == 3'd2)) ? pwdata[1:0] : 2'b11;

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      tdr     <= TDR_RST;
      load    <= 1'b0;
      cnt_dw  <= 1'b0;
      cnt_en  <= 1'b0;
      clk_sel <= 2'b00;
      r_tsr   <= 2'b00;
    end else begin
      load <= w_commit && (w_reg == 3'd1) && pwdata[7];
      if (w_commit && (w_reg == 3'd0)) begin
        tdr <= pwdata;
      end
      if (w_commit && (w_reg == 3'd1)) begin
        cnt_dw  <= pwdata[5];
        cnt_en  <= pwdata[4];
        clk_sel <= pwdata[1:0];
      end
      // set pulses are ORed in after the clear mask, so a set wins a collision
      r_tsr <= (r_tsr & w_tsr_keep) | {udf_set, ovf_set};
    end
  end

`ifdef TIMER_INT_EN
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      r_tier  <= 2'b00;
      tmr_int <= 1'b0;
    end else begin
      if (w_commit && (w_reg == 3'd4)) begin
        r_tier <= pwdata[1:0];
      end
      tmr_int <= |(r_tsr & r_tier);
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_timer_apb_slave.sv
// Directed scoreboard bench for timer_apb_slave: a zero-wait instance (A)
// and a three-wait-state instance (B) share one APB bus.
`default_nettype none

module tb_timer_apb_slave;

  logic       pclk = 1'b0;
  logic       presetn = 1'b0;
  logic       psel_a = 1'b0, psel_b = 1'b0, penable = 1'b0, pwrite = 1'b0;
  logic [7:0] paddr = 8'h00, pwdata = 8'h00, tcnt = 8'h3C;
  logic       ovf_set = 1'b0, udf_set = 1'b0;

  logic [7:0] a_prdata, a_tdr, b_prdata, b_tdr;
  logic       a_pready, a_pslverr, a_load, a_dw, a_en;
  logic       b_pready, b_pslverr, b_load, b_dw, b_en;
  logic [1:0] a_clk_sel, b_clk_sel;
`ifdef TIMER_INT_EN
  logic       a_int, b_int;
`endif

  always #5 pclk = ~pclk;

  timer_apb_slave #(.ADDR_W(8), .WAIT_CYCLES(0), .TDR_RST(8'hA5)) u_dut_a (
    .pclk(pclk), .presetn(presetn), .psel(psel_a), .penable(penable),
    .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata), .prdata(a_prdata),
    .pready(a_pready), .pslverr(a_pslverr), .tdr(a_tdr), .load(a_load),
    .cnt_dw(a_dw), .cnt_en(a_en), .clk_sel(a_clk_sel), .tcnt(tcnt),
    .ovf_set(ovf_set),
`ifdef TIMER_INT_EN
    .tmr_int(a_int),
`endif
    .udf_set(udf_set)
  );

  timer_apb_slave #(.ADDR_W(8), .WAIT_CYCLES(3), .TDR_RST(8'h00)) u_dut_b (
    .pclk(pclk), .presetn(presetn), .psel(psel_b), .penable(penable),
    .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata), .prdata(b_prdata),
    .pready(b_pready), .pslverr(b_pslverr), .tdr(b_tdr), .load(b_load),
    .cnt_dw(b_dw), .cnt_en(b_en), .clk_sel(b_clk_sel), .tcnt(tcnt),
    .ovf_set(ovf_set),
`ifdef TIMER_INT_EN
    .tmr_int(b_int),
`endif
    .udf_set(udf_set)
  );

  typedef struct {
    logic [7:0] data;
    logic       err;
    bit         chk_data;
    int         waits;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic xfer(input bit on_b, input bit wr, input logic [7:0] addr,
                      input logic [7:0] wdata, input logic [7:0] exp_data,
                      input bit exp_err, input int exp_wait, input bit udf_at_done);
    exp_t e;
    int   n;
    bit   seen;
    e.data = exp_data; e.err = exp_err; e.chk_data = !wr; e.waits = exp_wait;
    sb.push_back(e);
    @(posedge pclk); #1;
    if (on_b) psel_b = 1'b1; else psel_a = 1'b1;
    pwrite = wr; paddr = addr; pwdata = wdata; penable = 1'b0;
    @(posedge pclk); #1;
    penable = 1'b1;
    n = 0; seen = 1'b0;
    while (!seen && n < 40) begin
      @(negedge pclk);
      if ((on_b ? b_pready : a_pready) === 1'b1) begin
        seen = 1'b1;
      end else begin
        if (n == 0) check("pslverr_while_busy", on_b ? b_pslverr : a_pslverr, 0);
        n++;
      end
    end
    check("pready_seen", seen, 1);
    e = sb.pop_front();
    if (seen) begin
      check("wait_cycles", n, e.waits);
      check("pslverr", on_b ? b_pslverr : a_pslverr, e.err);
      if (e.chk_data) check("prdata", on_b ? b_prdata : a_prdata, e.data);
      if (udf_at_done) udf_set = 1'b1;
    end
    @(posedge pclk); #1;
    psel_a = 1'b0; psel_b = 1'b0; penable = 1'b0; udf_set = 1'b0;
    check("prdata_cleared", on_b ? b_prdata : a_prdata, 0);
  endtask

  task automatic rd_a(input logic [7:0] addr, input logic [7:0] exp, input bit err);
    xfer(1'b0, 1'b0, addr, 8'h00, exp, err, 0, 1'b0);
  endtask

  task automatic wr_a(input logic [7:0] addr, input logic [7:0] data, input bit err);
    xfer(1'b0, 1'b1, addr, data, 8'h00, err, 0, 1'b0);
  endtask

  task automatic pulse(input logic o, input logic u);
    @(posedge pclk); #1;
    ovf_set = o; udf_set = u;
    @(posedge pclk); #1;
    ovf_set = 1'b0; udf_set = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit saw;
    repeat (3) @(posedge pclk);
    @(negedge pclk);
    check("rst_tdr_a", a_tdr, 8'hA5);
    check("rst_tdr_b", b_tdr, 8'h00);
    check("rst_pready", a_pready, 0);
    check("rst_pslverr", a_pslverr, 0);
    check("rst_prdata", a_prdata, 0);
    check("rst_ctrl", {a_load, a_dw, a_en, a_clk_sel}, 0);
    @(posedge pclk); #1;
    presetn = 1'b1;

    rd_a(8'h00, 8'hA5, 1'b0);
    rd_a(8'h01, 8'h00, 1'b0);
    rd_a(8'h02, 8'h00, 1'b0);
    rd_a(8'h03, 8'h3C, 1'b0);

    wr_a(8'h00, 8'hFF, 1'b0);
    wr_a(8'h01, 8'h80, 1'b0);
    @(negedge pclk);
    check("load_pulse", a_load, 1);
    check("tdr_at_load", a_tdr, 8'hFF);
    @(negedge pclk);
    check("load_single_cycle", a_load, 0);
    wr_a(8'h01, 8'h32, 1'b0);
    @(negedge pclk);
    check("load_not_stored", a_load, 0);
    check("ctrl_after_32", {a_dw, a_en, a_clk_sel}, 4'b1110);
    rd_a(8'h01, 8'h32, 1'b0);
    wr_a(8'h01, 8'h4D, 1'b0);
    rd_a(8'h01, 8'h01, 1'b0);
    wr_a(8'h01, 8'h32, 1'b0);

    pulse(1'b0, 1'b1);
    rd_a(8'h02, 8'h02, 1'b0);
    wr_a(8'h02, 8'h00, 1'b0);
    rd_a(8'h02, 8'h00, 1'b0);
    pulse(1'b1, 1'b1);
    pulse(1'b1, 1'b0);
    rd_a(8'h02, 8'h03, 1'b0);
    wr_a(8'h02, 8'h01, 1'b0);
    rd_a(8'h02, 8'h01, 1'b0);
    wr_a(8'h02, 8'h00, 1'b0);
    xfer(1'b0, 1'b1, 8'h02, 8'h00, 8'h00, 1'b0, 0, 1'b1);
    rd_a(8'h02, 8'h02, 1'b0);

    wr_a(8'h03, 8'h55, 1'b1);
    rd_a(8'h03, 8'h3C, 1'b0);
    rd_a(8'h07, 8'h00, 1'b1);
    wr_a(8'h10, 8'h99, 1'b1);
    rd_a(8'h10, 8'h00, 1'b1);
    rd_a(8'h00, 8'hFF, 1'b0);
    tcnt = 8'hC3;
    rd_a(8'h03, 8'hC3, 1'b0);

    xfer(1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 3, 1'b0);
    xfer(1'b1, 1'b1, 8'h00, 8'h77, 8'h00, 1'b0, 3, 1'b0);
    xfer(1'b1, 1'b0, 8'h00, 8'h00, 8'h77, 1'b0, 3, 1'b0);
    xfer(1'b1, 1'b1, 8'h03, 8'h12, 8'h00, 1'b1, 3, 1'b0);

    @(posedge pclk); #1;
    psel_b = 1'b1; pwrite = 1'b1; paddr = 8'h00; pwdata = 8'h11; penable = 1'b0;
    @(posedge pclk); #1;
    penable = 1'b1;
    @(posedge pclk); #1;
    psel_b = 1'b0; penable = 1'b0;
    saw = 1'b0;
    repeat (6) begin
      @(negedge pclk);
      if (b_pready === 1'b1) saw = 1'b1;
    end
    check("abort_no_pready", saw, 0);
    check("abort_tdr_b", b_tdr, 8'h77);
    xfer(1'b1, 1'b0, 8'h00, 8'h00, 8'h77, 1'b0, 3, 1'b0);

    wr_a(8'h02, 8'h00, 1'b0);
`ifdef TIMER_INT_EN
    wr_a(8'h04, 8'h02, 1'b0);
    rd_a(8'h04, 8'h02, 1'b0);
    check("int_idle", a_int, 0);
    pulse(1'b1, 1'b0);
    repeat (2) @(negedge pclk);
    check("int_masked_ovf", a_int, 0);
    wr_a(8'h02, 8'h00, 1'b0);
    pulse(1'b0, 1'b1);
    @(negedge pclk);
    check("int_latency", a_int, 0);
    @(negedge pclk);
    check("int_asserted", a_int, 1);
    wr_a(8'h02, 8'h00, 1'b0);
    @(negedge pclk);
    check("int_hold_one_cycle", a_int, 1);
    @(negedge pclk);
    check("int_cleared", a_int, 0);
`else
    rd_a(8'h04, 8'h00, 1'b1);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/timer_apb_slave.md
Name: timer_apb_slave

Overview:
- APB responder (completer) and register file for the 8-bit timer; the other end of the CPU bus-master BFM used by the timer benches.
- Decodes APB transfers and holds TDR/TCR/TSR.
- Drives control outputs to the counter core and captures the counter's overflow/underflow set pulses into TSR with write-0-to-clear semantics.
- Sits between the APB fabric and the timer counter core, both on pclk.

Parameters:
- ADDR_W, 8, paddr width; only the low 3 bits are decoded, upper bits must be 0.
- WAIT_CYCLES, 0, number of extra ACCESS cycles with pready low before completion (0..15).
- TDR_RST, 8'h00, reset value of TDR.

Ports:
- pclk  in  1  system/APB clock.
- presetn  in  1  asynchronous active-low reset.
- psel  in  1  APB select.
- penable  in  1  APB enable (ACCESS phase).
- pwrite  in  1  1 = write, 0 = read.
- paddr  in  ADDR_W  byte address.
- pwdata  in  8  write data.
- prdata  out  8  read data; valid when pready=1 in ACCESS.
- pready  out  1  transfer completion.
- pslverr  out  1  error response, valid with pready.
- tdr  out  8  reload value to the counter.
- load  out  1  one-pclk pulse: counter loads tdr.
- cnt_dw  out  1  1 = count down.
- cnt_en  out  1  counter enable.
- clk_sel  out  2  prescaler select: 00 /2, 01 /4, 10 /8, 11 /16.
- tcnt  in  8  live counter value (read-only register).
- ovf_set  in  1  counter overflow pulse.
- udf_set  in  1  counter underflow pulse.

Behaviour:
- Register map:
  - 0x0 TDR: R/W.
  - 0x1 TCR: bit7 load, bit5 dw, bit4 en, bits1:0 clk_sel; bits 6, 3:2 reserved, read 0, writes ignored.
  - 0x2 TSR: bit1 udf, bit0 ovf; bits 7:2 read 0.
  - 0x3 TCNT: read-only, returns tcnt.
  - Any other address: pslverr=1 on completion, no state change, prdata=0.
- Reset: prdata=0, pready=0, pslverr=0, tdr=TDR_RST, TCR=0, TSR=0, load=0, all outputs low.
- FSM, states IDLE, SETUP, ACCESS, WAIT:
  - IDLE -> SETUP when psel & ~penable.
  - SETUP -> ACCESS next cycle (protocol requires penable=1).
  - In ACCESS: WAIT_CYCLES=0 -> pready=1 in the same cycle. Otherwise -> WAIT, where a 4-bit counter counts WAIT_CYCLES cycles with pready=0, then pready=1 for exactly one cycle.
  - After completion -> SETUP if psel & ~penable (back-to-back transfer), else IDLE.
  - psel dropping in SETUP or WAIT aborts to IDLE with no register side effect.
- Writes commit on the pready=1 cycle only. Reads: prdata is combinationally selected and registered so it is stable on the pready=1 cycle; prdata returns to 0 in the next cycle.
- TCR bit7 (load) is not stored; a write with pwdata[7]=1 produces a single-cycle load pulse in the cycle after commit. TCR reads return bit7=0. Example: writing 8'h80 then 8'h32 yields load then dw=1, en=1, clk_sel=10.
- TSR write: each written 0 clears that flag; each written 1 leaves it unchanged. Writing 8'h00 clears both flags.
- Set-vs-clear collision in the same cycle: the set pulse wins and the flag stays 1.
- Flags are sticky until cleared; a repeated set while already 1 has no further effect.
- TCNT write: pslverr=1, ignored.
- pslverr is only ever 1 on the pready=1 cycle.
- Async reset mid-transfer: immediately returns to IDLE with reset values; the transfer is lost.

Optional Feature:
- Macro: TIMER_INT_EN.
- Defined:
  - Adds TIER at 0x4 (bit1 udf_ie, bit0 ovf_ie, R/W, reset 0).
  - Adds output tmr_int (1 bit), registered = |(TSR[1:0] & TIER[1:0]), asserting one cycle after the flag/enable condition becomes true.
- Undefined: no TIER or tmr_int; 0x4 decodes as an invalid address (pslverr=1).

Test Plan:
- Reset, then read all registers -> TDR=TDR_RST, TCR=00, TSR=00, TCNT=tcnt; pslverr=0 throughout.
- Write TDR=FF, TCR=80, TCR=32 -> one load pulse with tdr=FF; then cnt_dw=1, cnt_en=1, clk_sel=10; TCR reads 32.
- Pulse udf_set -> TSR reads 02. Write TSR=00 -> TSR reads 00. Pulse ovf_set+udf_set, write TSR=01 -> reads 01.
- udf_set pulsed in the same cycle as a TSR=00 write commit -> TSR reads 02 afterwards.
- WAIT_CYCLES=3 -> pready is high exactly 3 cycles after the first ACCESS cycle. Write to 0x3 and read of 0x7 -> pslverr=1, no state change. psel dropped mid-WAIT -> no write committed.
- TIMER_INT_EN: TIER=02, then udf_set -> tmr_int=1. Write TSR=00 -> tmr_int=0 next cycle.
